// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
//   DATA_WIDTH / ADDR_WIDTH : default register width and index width
//   NUM_REGS                : register count (2**ADDR_WIDTH)
//   ZERO_REG                : hard-wired zero register index
//   busy_vec_t              : one busy bit per register
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [NUM_REGS-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the scoreboarded register file.
// Build option: REGFILE_BYPASS_EN enables write-through forwarding.
// Ports:
//   idx      - read index
//   regs     - flattened register storage
//   busy     - registered busy bits
//   wr_en    - writeback valid (already qualified by reset)
//   wr_idx   - writeback index
//   wr_data  - writeback data
//   rd_data  - read data
//   src_busy - this port's source is awaiting writeback
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int unsigned NumRegs    = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]               idx,
  input  logic [NumRegs-1:0][DATA_WIDTH-1:0]  regs,
  input  logic [NumRegs-1:0]                  busy,
  input  logic                                wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic                                src_busy
);

  logic is_zero;
  assign is_zero = (idx == ADDR_WIDTH'(ZERO_REG));

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_idx, wr_data};
`endif

  always_comb begin
    rd_data  = regs[idx];
    src_busy = busy[idx];
`ifdef REGFILE_BYPASS_EN
    // The value being written this cycle is the one the reader wants.
    if (wr_en && (wr_idx == idx)) begin
      rd_data  = wr_data;
      src_busy = 1'b0;
    end
`endif
    if (is_zero) begin
      rd_data  = '0;
      src_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard.
// Build option: REGFILE_BYPASS_EN enables write-through forwarding on reads.
// Ports:
//   clock, ctrl_reset_n             - rising-edge clock, async active-low reset
//   ctrl_writeEnable/_writeReg      - writeback valid / destination
//   data_writeReg                   - writeback data
//   ctrl_issueEnable/_issueReg      - issuing instruction claims a destination
//   ctrl_readRegA/B, data_readRegA/B- two independent combinational read ports
//   stall                           - a read source is still busy
//   busy_count                      - registered popcount of busy bits
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic                  ctrl_issueEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NumRegs-1:0]                 busy_q, busy_d;
  logic [ADDR_WIDTH:0]                busy_count_q, busy_count_d;
  logic                               wr_fwd;
  logic                               stall_a, stall_b;

  // Storage; register 0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      regs_q <= '0;
    end else if (ctrl_writeEnable && (ctrl_writeReg != ADDR_WIDTH'(ZERO_REG))) begin
      regs_q[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Issue is applied after writeback so a simultaneous new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (ctrl_writeEnable) busy_d[ctrl_writeReg] = 1'b0;
    if (ctrl_issueEnable) busy_d[ctrl_issueReg] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NumRegs; i++) begin
      busy_count_d = busy_count_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Forwarding must not leak write data onto the read ports while in reset.
  assign wr_fwd = ctrl_writeEnable & ctrl_reset_n;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NumRegs    (NumRegs)
  ) u_read_a (
    .idx      (ctrl_readRegA),
    .regs     (regs_q),
    .busy     (busy_q),
    .wr_en    (wr_fwd),
    .wr_idx   (ctrl_writeReg),
    .wr_data  (data_writeReg),
    .rd_data  (data_readRegA),
    .src_busy (stall_a)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NumRegs    (NumRegs)
  ) u_read_b (
    .idx      (ctrl_readRegB),
    .regs     (regs_q),
    .busy     (busy_q),
    .wr_en    (wr_fwd),
    .wr_idx   (ctrl_writeReg),
    .wr_data  (data_writeReg),
    .rd_data  (data_readRegB),
    .src_busy (stall_b)
  );

  assign stall      = stall_a | stall_b;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        ctrl_issueEnable;
  logic [4:0]  ctrl_issueReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        stall;
  logic [5:0]  busy_count;

  int n_pass  = 0;
  int n_total = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  regfile_sb dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_issueEnable (ctrl_issueEnable),
    .ctrl_issueReg    (ctrl_issueReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .stall            (stall),
    .busy_count       (busy_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ctrl_writeEnable = 1'b0;
    ctrl_issueEnable = 1'b0;
  endtask

  initial begin
    ctrl_reset_n     = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_issueEnable = 1'b0;
    ctrl_issueReg    = '0;
    ctrl_readRegA    = 5'd5;
    ctrl_readRegB    = 5'd31;
    #12;
    check("rst_rdA", data_readRegA, 0);
    check("rst_rdB", data_readRegB, 0);
    check("rst_stall", stall, 0);
    check("rst_count", busy_count, 0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    tick();
    check("post_rst_rdA", data_readRegA, 0);
    check("post_rst_count", busy_count, 0);

    // Plain write, then write to r0 is dropped.
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hDEADBEEF;
    tick();
    idle(); ctrl_readRegA = 5'd7;
    #1 check("wr_r7", data_readRegA, 32'hDEADBEEF);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
    tick();
    idle(); ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd7;
    #1 check("wr_r0", data_readRegA, 0);
    check("r7_on_B", data_readRegB, 32'hDEADBEEF);

    // Issue r3, then writeback clears busy.
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd3;
    tick();
    idle(); ctrl_readRegB = 5'd3;
    #1 check("iss_r3_stall", stall, 1);
    check("iss_r3_count", busy_count, 1);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h55;
    #1 check("wb_r3_same_stall", stall, Bypass ? 0 : 1);
    check("wb_r3_same_data", data_readRegB, Bypass ? 32'h55 : 32'h0);
    tick();
    idle();
    #1 check("wb_r3_stall", stall, 0);
    check("wb_r3_count", busy_count, 0);
    check("wb_r3_data", data_readRegB, 32'h55);

    // Simultaneous issue and writeback: data written, still busy.
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd9;
    tick();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'hA;
    tick();
    idle(); ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd0;
    #1 check("coll_r9_data", data_readRegA, 32'hA);
    check("coll_r9_stall", stall, 1);
    check("coll_r9_count", busy_count, 1);

    // Write to non-busy r4, then same-cycle read of an overwrite.
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h11;
    tick();
    ctrl_writeReg = 5'd4; data_writeReg = 32'h77;
    ctrl_readRegA = 5'd4; ctrl_readRegB = 5'd4;
    #1 check("byp_r4_A", data_readRegA, Bypass ? 32'h77 : 32'h11);
    check("byp_r4_stall", stall, 0);
    tick();
    idle();
    #1 check("r4_after", data_readRegB, 32'h77);
    check("r4_count", busy_count, 1);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'hB;
    tick();
    idle();
    #1 check("r9_clear_count", busy_count, 0);

    // Fill the scoreboard; r0 issue and re-issue of a busy reg change nothing.
    for (int i = 1; i < 32; i++) begin
      ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'(i);
      tick();
    end
    ctrl_issueReg = 5'd0;
    tick();
    ctrl_issueReg = 5'd5;
    tick();
    idle(); ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd3;
    #1 check("full_count", busy_count, 31);
    check("full_stall", stall, 1);

    // Asynchronous reset in the middle of the high phase.
    #1 ctrl_reset_n = 1'b0;
    #1 check("arst_rdA", data_readRegA, 0);
    check("arst_rdB", data_readRegB, 0);
    check("arst_stall", stall, 0);
    check("arst_count", busy_count, 0);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hCAFE;
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd7;
    #1 check("arst_fwd", data_readRegA, 0);
    tick();
    check("arst_wr_ign", data_readRegA, 0);
    check("arst_iss_ign", busy_count, 0);
    idle();
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    tick();
    check("rel_count", busy_count, 0);
    check("rel_stall", stall, 0);
    check("rel_rdA", data_readRegA, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of each register and data port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width; register count is 2**ADDR_WIDTH (32).
REQ-003 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-004 SHALL have port ctrl_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ctrl_writeEnable  input  1  writeback valid.
REQ-006 SHALL have port ctrl_writeReg  input  ADDR_WIDTH  writeback destination index.
REQ-007 SHALL have port data_writeReg  input  DATA_WIDTH  writeback data.
REQ-008 SHALL have port ctrl_issueEnable  input  1  an instruction claiming a destination issues this cycle.
REQ-009 SHALL have port ctrl_issueReg  input  ADDR_WIDTH  issuing instruction's destination index.
REQ-010 SHALL have ports ctrl_readRegA / ctrl_readRegB  input  ADDR_WIDTH  read indices.
REQ-011 SHALL have ports data_readRegA / data_readRegB  output  DATA_WIDTH  read data.
REQ-012 SHALL have port stall  output  1  a read source is awaiting writeback.
REQ-013 SHALL have port busy_count  output  ADDR_WIDTH+1  number of registers currently busy.

Function
REQ-014 Storage SHALL be 32 registers; register 0 SHALL read 0 always, never be written, never be busy.
REQ-015 Write SHALL occur at rising clock when ctrl_writeEnable=1 and ctrl_writeReg!=0; other registers unchanged.
REQ-016 Reads SHALL be combinational: data_readRegX = reg[ctrl_readRegX], zero-latency, both ports independent, same index on both ports legal.
REQ-017 Busy bit[i] SHALL set at rising clock when ctrl_issueEnable=1 and ctrl_issueReg=i, i!=0.
REQ-018 Busy bit[i] SHALL clear at rising clock when ctrl_writeEnable=1 and ctrl_writeReg=i, unless REQ-019 applies.
REQ-019 Simultaneous issue and writeback to same register SHALL leave busy set (new producer wins); data still written.
REQ-020 Issue to already-busy register SHALL keep it busy; writeback to non-busy register SHALL write data, busy stays clear.
REQ-021 stall SHALL be combinational: busy[ctrl_readRegA] OR busy[ctrl_readRegB], using registered busy bits only.
REQ-022 busy_count SHALL be registered and equal popcount of busy bits after each edge; range 0..31, never wraps.
REQ-023 Block SHALL not gate writes or issues on stall; honouring stall is upstream's job.

Reset
REQ-024 Assertion of ctrl_reset_n=0 SHALL immediately clear all registers, all busy bits, busy_count, independent of clock.
REQ-025 During reset all read outputs SHALL be 0, stall 0, busy_count 0; writes and issues ignored.
REQ-026 Reset mid-operation SHALL discard pending busy state; first edge after deassertion SHALL behave as from empty state.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control write-through forwarding.
REQ-028 With REGFILE_BYPASS_EN: read index equal to ctrl_writeReg (nonzero) with ctrl_writeEnable=1 SHALL return data_writeReg same cycle, and that read port SHALL not contribute to stall.
REQ-029 Without REGFILE_BYPASS_EN: such read SHALL return old stored value and stall per REQ-021.

Structure
REQ-030 Package regfile_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, NUM_REGS, ZERO_REG constants and the busy-vector typedef.
REQ-031 One sub-module regfile_read_port SHALL implement a single read port (index decode, zero-register override, optional bypass), instantiated twice.

Verification
REQ-032 Reset then read r5, r31 -> both 0, stall=0, busy_count=0.
REQ-033 Write r7=0xDEADBEEF, next cycle readA=7 -> 0xDEADBEEF; write r0=0x1234 -> r0 reads 0.
REQ-034 Issue r3, next cycle readB=3 -> stall=1, busy_count=1; writeback r3=0x55 -> next cycle stall=0, busy_count=0, readB=0x55.
REQ-035 Busy r9; same cycle issue r9 and writeback r9=0xA -> r9=0xA, still busy, busy_count=1.
REQ-036 Write r4=0x77 with readA=4 same cycle -> 0x77 with bypass, prior value without.
REQ-037 Issue r1..r31 over 31 cycles -> busy_count=31; assert ctrl_reset_n=0 mid-clock -> outputs 0 immediately.
